// File: rtl/done_collector_pkg.sv
// Shared types and sizing for the start dispatcher / done collector pair.
package done_collector_pkg;

  localparam int unsigned DC_N    = 13;
  localparam int unsigned DC_ID_W = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } dc_state_e;

endpackage

// File: rtl/done_prio_enc.sv
// Circular first-set search over the pending vector, starting at start_i.
module done_prio_enc
  import done_collector_pkg::*;
#(
  parameter int unsigned N    = DC_N,
  parameter int unsigned ID_W = DC_ID_W
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic            found_o,
  output logic [ID_W-1:0] idx_o
);

  int unsigned     pos;
  logic [ID_W-1:0] cand;

  // Walk offsets from far to near so the nearest request is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    cand    = '0;
    for (int unsigned k = N; k > 0; k--) begin
      pos = 32'(start_i) + k - 1;
      if (pos >= N) begin
        pos = pos - N;
      end
      cand = ID_W'(pos);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/done_collector.sv
// Collects per-unit completions and presents them one at a time on a valid/ready port.
// DONE_COLLECTOR_RR_EN selects round-robin instead of lowest-index-first service.
module done_collector
  import done_collector_pkg::*;
#(
  parameter int unsigned N    = DC_N,
  parameter int unsigned ID_W = DC_ID_W
) (
  input  logic            MHz10,
  input  logic            nrst,
  input  logic [N-1:0]    start_in,
  input  logic [N-1:0]    done_in,
  input  logic            done_ready,
  output logic [N-1:0]    avail,
  output logic            done_valid,
  output logic [ID_W-1:0] done_id,
  output logic            err
);

  localparam logic [N-1:0] UNIT_ONE = N'(1);

  dc_state_e       state_q, state_d;
  logic [N-1:0]    busy_q, busy_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [ID_W-1:0] done_id_q, done_id_d;
  logic            err_q, err_d;

  logic [N-1:0]    presented;
  logic [N-1:0]    start_ok;
  logic [N-1:0]    done_ok;
  logic [N-1:0]    grant_clr;
  logic            start_multi;
  logic            take;
  logic [ID_W-1:0] sel_start;
  logic            sel_found;
  logic [ID_W-1:0] sel_idx;

`ifdef DONE_COLLECTOR_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign sel_start = (ptr_q == ID_W'(N - 1)) ? '0 : ptr_q + ID_W'(1);
  assign ptr_d     = take ? sel_idx : ptr_q;

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= ID_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign sel_start = '0;
`endif

  done_prio_enc #(
    .N    (N),
    .ID_W (ID_W)
  ) u_prio (
    .req_i   (pending_q),
    .start_i (sel_start),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  assign done_valid = (state_q == ST_PRESENT);
  assign done_id    = done_id_q;
  assign err        = err_q;
  assign presented  = done_valid ? (UNIT_ONE << done_id_q) : '0;
  assign avail      = ~busy_q & ~pending_q & ~presented;

  // Illegal bits are dropped individually; a multi-hot start is dropped whole.
  assign start_multi = ($countones(start_in) > 1);
  assign start_ok    = start_multi ? '0 : (start_in & avail);
  assign done_ok     = done_in & busy_q;

  always_comb begin
    state_d   = state_q;
    done_id_d = done_id_q;
    grant_clr = '0;
    take      = sel_found && ((state_q == ST_IDLE) || done_ready);

    if (take) begin
      state_d   = ST_PRESENT;
      done_id_d = sel_idx;
      grant_clr = UNIT_ONE << sel_idx;
    end else if ((state_q == ST_PRESENT) && done_ready) begin
      state_d = ST_IDLE;
    end

    busy_d    = (busy_q & ~done_ok) | start_ok;
    pending_d = (pending_q | done_ok) & ~grant_clr;
    err_d     = err_q | start_multi | (|(start_in & ~avail)) | (|(done_in & ~busy_q));
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      busy_q    <= '0;
      pending_q <= '0;
      done_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_done_collector.sv
// Directed bench for done_collector with a per-cycle behavioural model and literal checkpoints.
module tb_done_collector;
  import done_collector_pkg::*;

  localparam int unsigned N    = DC_N;
  localparam int unsigned ID_W = DC_ID_W;
`ifdef DONE_COLLECTOR_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic            MHz10 = 1'b0;
  logic            nrst  = 1'b0;
  logic [N-1:0]    start_in = '0;
  logic [N-1:0]    done_in  = '0;
  logic            done_ready = 1'b0;
  logic [N-1:0]    avail;
  logic            done_valid;
  logic [ID_W-1:0] done_id;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  done_collector #(
    .N    (N),
    .ID_W (ID_W)
  ) dut (
    .MHz10      (MHz10),
    .nrst       (nrst),
    .start_in   (start_in),
    .done_in    (done_in),
    .done_ready (done_ready),
    .avail      (avail),
    .done_valid (done_valid),
    .done_id    (done_id),
    .err        (err)
  );

  always #5 MHz10 = ~MHz10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-unit flags plus the currently offered completion.
  bit          m_busy [N];
  bit          m_pend [N];
  bit          m_valid;
  bit          m_err;
  int unsigned m_id;
  int unsigned m_ptr;

  function automatic logic [N-1:0] m_avail_vec();
    logic [N-1:0] v;
    for (int unsigned i = 0; i < N; i++)
      v[i] = !m_busy[i] && !m_pend[i] && !(m_valid && m_id == i);
    return v;
  endfunction

  function automatic int m_pick();
    int unsigned first;
    first = RR_MODE ? (m_ptr + 1) % N : 0;
    for (int unsigned off = 0; off < N; off++)
      if (m_pend[(first + off) % N]) return int'((first + off) % N);
    return -1;
  endfunction

  always @(posedge MHz10 or negedge nrst) begin
    logic [N-1:0] av;
    int           g;
    bit           multi;
    if (!nrst) begin
      for (int unsigned i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_id    = 0;
      m_ptr   = N - 1;
    end else begin
      av    = m_avail_vec();
      g     = m_pick();
      multi = ($countones(start_in) > 1);
      if (multi) m_err = 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (done_in[i]) begin
          if (m_busy[i]) begin
            m_busy[i] = 1'b0;
            m_pend[i] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (start_in[i]) begin
          if (!av[i]) m_err = 1'b1;
          else if (!multi) m_busy[i] = 1'b1;
        end
      end
      if (!m_valid || done_ready) begin
        if (g >= 0) begin
          m_valid   = 1'b1;
          m_id      = g;
          m_pend[g] = 1'b0;
          m_ptr     = g;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge MHz10) begin
    chk("avail", 32'(avail), 32'(m_avail_vec()));
    chk("done_valid", 32'(done_valid), 32'(m_valid));
    if (m_valid) chk("done_id", 32'(done_id), m_id);
    chk("err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge MHz10);
    #1;
  endtask

  task automatic do_reset();
    nrst     = 1'b0;
    start_in = '0;
    done_in  = '0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  function automatic logic [N-1:0] bitv(input int unsigned i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] av;
    tick();
    chk("rst_avail", 32'(avail), 32'h1FFF);
    chk("rst_valid", 32'(done_valid), 0);
    chk("rst_id", 32'(done_id), 0);
    chk("rst_err", 32'(err), 0);
    nrst = 1'b1;
    tick();

    // first start takes unit 0 out of the free set
    start_in = 13'h0001;
    tick();
    start_in = '0;
    chk("start0_avail", 32'(avail), 32'h1FFE);
    done_ready = 1'b1;
    done_in = 13'h0001;
    tick();
    done_in = '0;
    tick();
    tick();

    // single completion: latency and release
    start_in = bitv(3);
    tick();
    start_in = '0;
    done_in  = bitv(3);
    tick();
    done_in = '0;
    tick();
    chk("lat_valid", 32'(done_valid), 1);
    chk("lat_id", 32'(done_id), 3);
    chk("lat_avail3_busy", 32'(avail[3]), 0);
    tick();
    chk("lat_avail3_free", 32'(avail[3]), 1);

    // simultaneous completions drain back to back
    start_in = bitv(2); tick();
    start_in = bitv(5); tick();
    start_in = bitv(9); tick();
    start_in = '0;
    done_in  = 13'h0224;
    tick();
    done_in = '0;
    tick();
    chk("burst_id0", 32'(done_id), 2);
    tick();
    chk("burst_id1", 32'(done_id), 5);
    tick();
    chk("burst_id2", 32'(done_id), 9);
    chk("burst_valid", 32'(done_valid), 1);
    tick();
    chk("burst_end_valid", 32'(done_valid), 0);
    chk("burst_end_avail", 32'(avail), 32'h1FFF);

    // back-pressure holds the presented id
    start_in = bitv(7);
    tick();
    start_in   = '0;
    done_ready = 1'b0;
    done_in    = bitv(7);
    tick();
    done_in = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_id", 32'(done_id), 7);
      chk("hold_avail7", 32'(avail[7]), 0);
      tick();
    end
    done_ready = 1'b1;
    tick();
    chk("hold_release_valid", 32'(done_valid), 0);
    chk("hold_release_avail7", 32'(avail[7]), 1);

    // multi-hot start is rejected
    start_in = bitv(2) | bitv(3);
    tick();
    start_in = '0;
    chk("multi_err", 32'(err), 1);
    chk("multi_avail", 32'(avail), 32'h1FFF);
    do_reset();

    // start and done on the same busy unit: done wins, start flagged
    start_in = bitv(8);
    tick();
    done_in = bitv(8);
    tick();
    start_in = '0;
    done_in  = '0;
    chk("sd_err", 32'(err), 1);
    tick();
    chk("sd_id", 32'(done_id), 8);
    tick();
    chk("sd_avail", 32'(avail), 32'h1FFF);
    do_reset();

    // contention between units 0 and 1 behind a held completion
    done_ready = 1'b0;
    start_in = bitv(12); tick();
    start_in = '0;
    done_in  = bitv(12); tick();
    done_in  = '0;       tick();
    chk("cont_block_id", 32'(done_id), 12);
    start_in = bitv(0); tick();
    start_in = bitv(1); tick();
    start_in = '0;
    done_in  = 13'h0003; tick();
    done_in  = '0;
    done_ready = 1'b1;
    tick();
    chk("cont_first", 32'(done_id), 0);
    tick();
    chk("cont_second", 32'(done_id), 1);
    tick();
    chk("cont_end_valid", 32'(done_valid), 0);

    // units 0 and 1 re-completing continuously; the model arbitrates
    for (int c = 0; c < 24; c++) begin
      av       = m_avail_vec();
      done_in  = '0;
      start_in = '0;
      for (int unsigned u = 0; u < 2; u++)
        if (m_busy[u]) done_in[u] = 1'b1;
      if (av[c % 2]) start_in = bitv(c % 2);
      else if (av[(c + 1) % 2]) start_in = bitv((c + 1) % 2);
      tick();
    end
    start_in = '0;
    done_in  = '0;
    for (int unsigned u = 0; u < 2; u++)
      if (m_busy[u]) done_in[u] = 1'b1;
    tick();
    done_in = '0;
    repeat (5) tick();
    chk("stream_drain_avail", 32'(avail), 32'h1FFF);

    // done on an idle unit is sticky error, no completion
    done_in = bitv(4);
    tick();
    done_in = '0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_done_err", 32'(err), 1);
      chk("idle_done_valid", 32'(done_valid), 0);
      tick();
    end
    done_ready = 1'b0;
    start_in = bitv(6); tick();
    start_in = '0;
    done_in  = bitv(6); tick();
    done_in  = '0;      tick();
    chk("pre_rst_valid", 32'(done_valid), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst_valid", 32'(done_valid), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_avail", 32'(avail), 32'h1FFF);
    chk("midrst_id", 32'(done_id), 0);
    tick();
    nrst = 1'b1;
    done_ready = 1'b1;
    repeat (3) tick();
    chk("post_rst_valid", 32'(done_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
